// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Number of bitstream words needed to cover the whole chain.
  function automatic int unsigned word_count(input int unsigned chain_len,
                                             input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator over the bits returned from the chain tail.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_en,
  input  logic        i_din,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic        w_fb;

  assign w_fb = r_crc[15] ^ i_din;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words into the fabric configuration chain, LSB first.
// Define CCFF_READBACK_CRC_EN to add a CRC-16 of the bits shifted out of ccff_tail.
//
// state     | meaning
// IDLE      | no load in progress; waits for start
// WAIT_WORD | chain stalled, waiting for the hold buffer to fill
// SHIFT     | one chain bit per cycle, shift_en high
// DONE      | all CHAIN_LEN bits shifted; one cycle, then IDLE
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 4096,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_CRC_EN
  ,
  output logic [15:0]       readback_crc
`endif
);

  localparam int BIDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  NWORDS   = CNT_W'(word_count(CHAIN_LEN, WORD_W));
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(WORD_W - 1);

  state_t              r_state;
  logic [WORD_W-1:0]   r_sr;
  logic [BIDX_W-1:0]   r_bidx;
  logic [WORD_W-1:0]   r_hb;
  logic                r_hv;
  logic [CNT_W-1:0]    r_bcnt;
  logic [CNT_W-1:0]    r_wcnt;
  logic                r_done;

  logic                w_busy;
  logic                w_shift;
  logic                w_xfer;

  assign w_busy    = (r_state == WAIT_WORD) || (r_state == SHIFT);
  assign w_shift   = (r_state == SHIFT);
  assign in_ready  = w_busy && !r_hv && (r_wcnt < NWORDS);
  assign w_xfer    = in_valid && in_ready;

  assign shift_en  = w_shift;
  assign ccff_head = w_shift & r_sr[r_bidx];
  assign busy      = w_busy;
  assign done      = r_done;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_bidx  <= '0;
      r_hb    <= '0;
      r_hv    <= 1'b0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= IDLE;
      r_bidx  <= '0;
      r_hv    <= 1'b0;
      r_bcnt  <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_hb   <= in_data;
        r_hv   <= 1'b1;
        r_wcnt <= r_wcnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT_WORD;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_hv    <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        WAIT_WORD: begin
          if (r_hv) begin
            r_sr    <= r_hb;
            r_hv    <= 1'b0;
            r_bidx  <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcnt <= r_bcnt + 1'b1;
          r_bidx <= r_bidx + 1'b1;
          if (r_bcnt == LAST_BIT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (r_bidx == LAST_IDX) begin
            r_bidx <= '0;
            // A word arriving on the last bit goes straight into SR to avoid a bubble.
            if (r_hv) begin
              r_sr <= r_hb;
              r_hv <= 1'b0;
            end else if (w_xfer) begin
              r_sr <= in_data;
              r_hv <= 1'b0;
            end else begin
              r_state <= WAIT_WORD;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_CRC_EN
  logic w_crc_clr;

  assign w_crc_clr = (r_state == IDLE) && start && !abort;

  ccff_crc16_serial u_crc (
    .i_clk   (prog_clk),
    .i_rst   (pReset),
    .i_clear (w_crc_clr),
    .i_en    (w_shift),
    .i_din   (ccff_tail),
    .o_crc   (readback_crc)
  );
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule
